// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed 7-segment display link: filters the scanned
// segment/digit lines and recovers the hex value and decimal point per position.
module seg7_scan_decoder #(
    parameter int NUM_DIG     = 8,
    parameter int STABLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 2**20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             seg_in,
    input  logic [NUM_DIG-1:0]     dig_in,
    output logic [4*NUM_DIG-1:0]   digit_val,
    output logic [NUM_DIG-1:0]     digit_ok,
    output logic [NUM_DIG-1:0]     dp_out,
    output logic                   frame_valid,
    output logic                   glyph_err,
    output logic                   dig_err,
    output logic                   stale
);

    localparam int SW = $clog2(STABLE_CYC);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [7:0]         segS1, segS2, segPrev;
    logic [NUM_DIG-1:0] digS1, digS2, digPrev;
    logic [SW-1:0]      stableCnt;
    logic               armed;
    logic [TW-1:0]      toCnt;
    logic [NUM_DIG-1:0] seen, seenNext, digLow;
    logic               sampleChanged, capture, digBlank, digSingle;
    logic               glyphHit, staleHit, frameDone;
    logic [3:0]         glyphVal;

    // Seven-segment pattern (g..a, active-low) to hex value; bit 4 flags a hit.
    function automatic logic [4:0] decodeGlyph(input logic [6:0] s);
        case (s)
            7'h40: return 5'h10;
            7'h79: return 5'h11;
            7'h24: return 5'h12;
            7'h30: return 5'h13;
            7'h19: return 5'h14;
            7'h12: return 5'h15;
            7'h02: return 5'h16;
            7'h78: return 5'h17;
            7'h00: return 5'h18;
            7'h10: return 5'h19;
            7'h08: return 5'h1A;
            7'h03: return 5'h1B;
            7'h46: return 5'h1C;
            7'h21: return 5'h1D;
            7'h06: return 5'h1E;
            7'h0E: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segS1   <= '0;
            segS2   <= '0;
            digS1   <= '0;
            digS2   <= '0;
            segPrev <= '0;
            digPrev <= '0;
        end else begin
            segS1   <= seg_in;
            segS2   <= segS1;
            digS1   <= dig_in;
            digS2   <= digS1;
            segPrev <= segS2;
            digPrev <= digS2;
        end
    end

    assign sampleChanged = {segS2, digS2} != {segPrev, digPrev};
    assign capture       = !sampleChanged && armed && (stableCnt == SW'(STABLE_CYC - 2));
    assign digLow        = ~digS2;
    assign digBlank      = (digLow == '0);
    assign digSingle     = !digBlank && ((digLow & (digLow - NUM_DIG'(1))) == '0);
    assign {glyphHit, glyphVal} = decodeGlyph(segS2[6:0]);
    assign staleHit      = !capture && (toCnt == TW'(TIMEOUT_CYC - 1));
    assign frameDone     = &seen;

    // Any change restarts the dwell; capture happens once per settled dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stableCnt <= '0;
            armed     <= 1'b0;
        end else if (sampleChanged) begin
            stableCnt <= '0;
            armed     <= 1'b1;
        end else begin
            if (stableCnt != SW'(STABLE_CYC - 1))
                stableCnt <= stableCnt + SW'(1);
            if (capture)
                armed <= 1'b0;
        end
    end

    always_comb begin
        seenNext = frameDone ? '0 : seen;
        if (capture && digSingle)
            seenNext = seenNext | digLow;
        if (staleHit)
            seenNext = '0;
    end

    // Timeout counter saturates so the stale event fires only once per silence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            toCnt <= '0;
        else if (capture)
            toCnt <= '0;
        else if (toCnt != TW'(TIMEOUT_CYC))
            toCnt <= toCnt + TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_val   <= '0;
            digit_ok    <= '0;
            dp_out      <= '0;
            seen        <= '0;
            frame_valid <= 1'b0;
            glyph_err   <= 1'b0;
            dig_err     <= 1'b0;
            stale       <= 1'b0;
        end else begin
            seen        <= seenNext;
            frame_valid <= frameDone;
            glyph_err   <= capture && digSingle && !glyphHit;
            dig_err     <= capture && !digBlank && !digSingle;
            if (capture && digSingle) begin
                for (int i = 0; i < NUM_DIG; i++) begin
                    if (digLow[i]) begin
                        dp_out[i]   <= ~segS2[7];
                        digit_ok[i] <= glyphHit;
                        if (glyphHit)
                            digit_val[4*i +: 4] <= glyphVal;
                    end
                end
                if (glyphHit)
                    stale <= 1'b0;
            end
            if (staleHit) begin
                stale    <= 1'b1;
                digit_ok <= '0;
            end
        end
    end

endmodule
